// File: rtl/stream_mux_nto1.sv
// ---------------------------------------------------------------------------
// stream_mux_nto1
//
// Purpose:
//   N-to-1 valid/ready stream multiplexer with a single registered output
//   stage. The channel to take a word from is chosen by one of two rules:
//     MODE = 0 : select-driven. The channel index comes from select_i.
//     MODE = 1 : round-robin. Channels are searched from an internal
//                priority pointer upward, and the search wraps at CH.
//   The output register is free when it is empty or is being drained.
//   When it is free, at most one channel is granted and is loaded, so the
//   output sustains one word per cycle with no bubble.
//
// Ports:
//   clk_i     in   1          clock, all state on rising edge
//   rst_i     in   1          synchronous active-high reset
//   data_i    in   CH*SIZE    channel k word at [k*SIZE +: SIZE]
//   valid_i   in   CH         channel k offers a word
//   ready_o   out  CH         channel k word accepted this cycle (one-hot/zero)
//   select_i  in   SELW       requested channel (MODE = 0 only)
//   data_o    out  SIZE       registered output word
//   chan_o    out  SELW       index of the channel that supplied data_o
//   valid_o   out  1          data_o/chan_o hold a word
//   ready_i   in   1          downstream accepts data_o this cycle
// ---------------------------------------------------------------------------
module stream_mux_nto1 #(
    parameter int SIZE = 32,
    parameter int CH   = 4,
    parameter int SELW = 2,
    parameter int MODE = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [CH*SIZE-1:0] data_i,
    input  logic [CH-1:0]      valid_i,
    output logic [CH-1:0]      ready_o,
    input  logic [SELW-1:0]    select_i,
    output logic [SIZE-1:0]    data_o,
    output logic [SELW-1:0]    chan_o,
    output logic               valid_o,
    input  logic               ready_i
);

    logic [SIZE-1:0] data_q, data_d;
    logic [SELW-1:0] chan_q, chan_d;
    logic [SELW-1:0] ptr_q,  ptr_d;
    logic            valid_q, valid_d;

    logic            free;
    logic            grant;
    logic [SELW-1:0] gnt_idx;
    logic [SIZE-1:0] gnt_word;
    int              idx;

    // The register can take a new word when empty or when it is being drained.
    assign free = ~valid_q | ready_i;

    // Grant selection. It depends only on the valid, select and pointer
    // signals. data_i never reaches ready_o.
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        grant   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (MODE == 0) begin
            // An out-of-range select_i matches no k, so it never grants.
            for (int k = 0; k < CH; k++) begin
                if (select_i == SELW'(k) && valid_i[k]) begin
                    grant   = 1'b1;
                    gnt_idx = SELW'(k);
                end
            end
        end else begin
            // Search order is ptr, ptr+1, ... wrapping modulo CH.
            // The first valid channel found wins.
            for (int i = 0; i < CH; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= CH) begin
                    idx = idx - CH;
                end
                if (!grant && valid_i[idx]) begin
                    grant   = 1'b1;
                    gnt_idx = SELW'(idx);
                end
            end
        end
    end

    // Word mux for the granted channel. It feeds only the data register.
    always_comb begin
        gnt_word = '0;
        for (int k = 0; k < CH; k++) begin
            if (gnt_idx == SELW'(k)) begin
                gnt_word = data_i[k*SIZE +: SIZE];
            end
        end
    end

    // Accept handshake. It is held off during reset so that no word is
    // consumed and then discarded.
    always_comb begin
        ready_o = '0;
        if (free && grant && !rst_i) begin
            ready_o[gnt_idx] = 1'b1;
        end
    end

    // Next-state logic. When the register is stalled, everything holds.
    // When it is free, a grant loads the new word. Without a grant the
    // register empties and data_o/chan_o keep their last values.
    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (free) begin
            valid_d = grant;
            if (grant) begin
                data_d = gnt_word;
                chan_d = gnt_idx;
                if (MODE == 1) begin
                    // Explicit wrap so non-power-of-2 CH returns to channel 0.
                    ptr_d = (int'(gnt_idx) == CH - 1) ? '0 : gnt_idx + SELW'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples its next value from the same pre-edge state. The data
    // register is reset as well, because data_o must read zero after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign chan_o  = chan_q;
    assign valid_o = valid_q;

endmodule

// File: doc/stream_mux_nto1.md
STREAM_MUX_NTO1 -- requirements
Module: stream_mux_nto1

Interface
REQ-001 SHALL have parameter SIZE, default 32: data width per channel in bits.
REQ-002 SHALL have parameter CH, default 4: number of input channels, legal range 2..16.
REQ-003 SHALL have parameter SELW, default 2: select/channel-index width, equal to ceil(log2(CH)).
REQ-004 SHALL have parameter MODE, default 0: 0 = select-driven, 1 = round-robin arbitration.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port data_i, input, CH*SIZE bits: channel k occupies bits [k*SIZE +: SIZE].
REQ-008 SHALL have port valid_i, input, CH bits: bit k set means channel k offers a word.
REQ-009 SHALL have port ready_o, output, CH bits: bit k set means channel k's word is accepted this cycle.
REQ-010 SHALL have port select_i, input, SELW bits: requested channel, used only when MODE=0.
REQ-011 SHALL have port data_o, output, SIZE bits: registered output word.
REQ-012 SHALL have port chan_o, output, SELW bits: index of the channel that supplied data_o.
REQ-013 SHALL have port valid_o, output, 1 bit: data_o/chan_o hold a word.
REQ-014 SHALL have port ready_i, input, 1 bit: downstream accepts data_o this cycle.

Function
REQ-015 A transfer on channel k SHALL occur when valid_i[k] and ready_o[k] are both 1 in the same cycle; an output transfer SHALL occur when valid_o and ready_i are both 1.
REQ-016 The output register is "free" when valid_o=0 or ready_i=1; ready_o SHALL be all zero when it is not free.
REQ-017 When free, at most one bit of ready_o SHALL be 1: the granted channel g, and only if valid_i[g]=1.
REQ-018 On a clock edge with a grant to g: data_o <= data_i[g], chan_o <= g, valid_o <= 1 (latency 1 cycle, sustained throughput 1 word/cycle).
REQ-019 On a clock edge when free and with no grant: valid_o <= 0; data_o and chan_o hold their values.
REQ-020 While valid_o=1 and ready_i=0: data_o, chan_o and valid_o SHALL remain unchanged (no overwrite, no loss).
REQ-021 MODE=0: g = select_i; no grant if select_i >= CH or valid_i[select_i]=0; other channels are never granted.
REQ-022 MODE=1: an internal pointer ptr (SELW bits) holds the highest-priority channel; g = first k with valid_i[k]=1 searching ptr, ptr+1, ... wrapping modulo CH.
REQ-023 MODE=1: after a grant to g, ptr <= (g+1) mod CH (wrap from CH-1 to 0, also for non-power-of-2 CH); without a grant ptr holds.
REQ-024 ready_o SHALL depend combinationally on valid_i, select_i, ready_i and state; no combinational path from data_i to any output.
REQ-025 Simultaneous output drain and new grant in the same cycle SHALL load the new word (back-to-back, no bubble).

Reset
REQ-026 While rst_i=1 at a clock edge: valid_o <= 0, data_o <= 0, chan_o <= 0, ptr <= 0.
REQ-027 During any cycle with rst_i=1, ready_o SHALL be all zero, so no input word is consumed.
REQ-028 Reset asserted mid-stream SHALL discard any held output word; the first grant after release SHALL follow REQ-021/REQ-022 with ptr=0.

Verification
REQ-029 Reset: hold rst_i=1 for 2 cycles with all valid_i=1 -> valid_o=0, data_o=0, chan_o=0, ready_o=0000.
REQ-030 MODE=0, CH=4: select_i=2, valid_i=0100, data ch2=0xDEADBEEF, ready_i=1 -> ready_o=0100, next cycle data_o=0xDEADBEEF, chan_o=2, valid_o=1.
REQ-031 MODE=0: select_i=3, valid_i=0111 -> ready_o=0000, valid_o falls to 0 after any pending drain.
REQ-032 MODE=1: valid_i=1111 held, ready_i=1 for 5 cycles -> chan_o sequence 0,1,2,3,0.
REQ-033 Backpressure: valid_o=1 with word 0x12345678, ready_i=0 for 3 cycles -> data_o stable, ready_o=0000; ready_i=1 -> next queued word loaded the following cycle, no word lost or duplicated.
REQ-034 MODE=1, CH=3: ptr=2, valid_i=011 -> grant 0, ptr becomes 1; then valid_i=100 -> grant 2, ptr wraps to 0.
